// File: rtl/gcd_controller.sv
`default_nettype none
// ============================================================================
//  Module   : gcd_controller
//  Purpose  : Moore control FSM for a subtractive GCD datapath. Loads the
//             A/B operand registers, repeatedly replaces the larger register
//             with the difference until they match, then captures A into the
//             answer register. Zero operands, an inconsistent compare-flag
//             set, or running out of iterations end the run with err=1.
//  Ports    : clk, rst                   - clock, sync active-high reset
//             start                      - run request (honoured in IDLE only)
//             a_gt_b, a_lt_b, a_eq_b     - datapath compare flags
//             a_zero, b_zero             - datapath zero flags
//             a_ld, b_ld, a_sel, b_sel   - operand register load / mux select
//             ans_ld                     - answer register load
//             busy, done, err            - status
//             iter_cnt                   - subtract steps in current/last run
//  Revision : 1.0 - initial release
// ============================================================================
module gcd_controller #(
  parameter logic [15:0] ITER_MAX = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        a_gt_b,
  input  logic        a_lt_b,
  input  logic        a_eq_b,
  input  logic        a_zero,
  input  logic        b_zero,
  output logic        a_ld,
  output logic        b_ld,
  output logic        a_sel,
  output logic        b_sel,
  output logic        ans_ld,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [15:0] iter_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_COMPARE = 3'd2,
    S_SUB_A   = 3'd3,
    S_SUB_B   = 3'd4,
    S_WRITE   = 3'd5,
    S_DONE    = 3'd6
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        w_set_err;
  logic [15:0] r_iter;
  logic        r_err;
  logic        w_iter_max;

  assign w_iter_max = (r_iter == ITER_MAX);

  // Next-state logic; w_set_err flags every failing exit from COMPARE.
  always_comb begin
    w_next    = r_state;
    w_set_err = 1'b0;
    case (r_state)
      S_IDLE:    if (start) w_next = S_LOAD;
      S_LOAD:    w_next = S_COMPARE;
      S_COMPARE: begin
        if (a_zero || b_zero) begin
          w_next    = S_DONE;
          w_set_err = 1'b1;
        end else if (a_eq_b) begin
          w_next = S_WRITE;
        end else if (a_gt_b || a_lt_b) begin
          // Abort rather than step once the iteration budget is spent, so
          // the counter can never wrap.
          if (w_iter_max) begin
            w_next    = S_DONE;
            w_set_err = 1'b1;
          end else begin
            w_next = a_gt_b ? S_SUB_A : S_SUB_B;
          end
        end else begin
          // No flag at all means the datapath is inconsistent.
          w_next    = S_DONE;
          w_set_err = 1'b1;
        end
      end
      S_SUB_A:   w_next = S_COMPARE;
      S_SUB_B:   w_next = S_COMPARE;
      S_WRITE:   w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_iter  <= 16'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == S_LOAD) begin
        r_iter <= 16'd0;
        r_err  <= 1'b0;
      end else if ((r_state == S_SUB_A) || (r_state == S_SUB_B)) begin
        r_iter <= r_iter + 16'd1;
      end
      if (w_set_err) r_err <= 1'b1;
    end
  end

  // Moore output decode: control strobes depend on the state register only.
  always_comb begin
    a_ld   = 1'b0;
    b_ld   = 1'b0;
    a_sel  = 1'b0;
    b_sel  = 1'b0;
    ans_ld = 1'b0;
    done   = 1'b0;
    busy   = (r_state != S_IDLE);
    case (r_state)
      S_LOAD: begin
        a_ld = 1'b1;
        b_ld = 1'b1;
      end
      S_SUB_A: begin
        a_ld  = 1'b1;
        a_sel = 1'b1;
      end
      S_SUB_B: begin
        b_ld  = 1'b1;
        b_sel = 1'b1;
      end
      S_WRITE: ans_ld = 1'b1;
      S_DONE:  done   = 1'b1;
      default: ;
    endcase
  end

  assign err      = r_err;
  assign iter_cnt = r_iter;

endmodule
`default_nettype wire

// File: tb/tb_gcd_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_controller
//  Purpose  : Directed self-checking bench for gcd_controller. Contains a
//             small behavioural A/B/answer datapath driven by the controller.
//             The DUT uses ITER_MAX=10 so the iteration limit is reachable.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_gcd_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        a_gt_b, a_lt_b, a_eq_b, a_zero, b_zero;
  logic        a_ld, b_ld, a_sel, b_sel, ans_ld;
  logic        busy, done, err;
  logic [15:0] iter_cnt;

  logic [15:0] r_a, r_b, r_ans;
  logic [15:0] opa, opb;
  logic        kill_flags;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gcd_controller #(.ITER_MAX(16'd10)) u_dut (
    .clk(clk), .rst(rst), .start(start),
    .a_gt_b(a_gt_b), .a_lt_b(a_lt_b), .a_eq_b(a_eq_b),
    .a_zero(a_zero), .b_zero(b_zero),
    .a_ld(a_ld), .b_ld(b_ld), .a_sel(a_sel), .b_sel(b_sel),
    .ans_ld(ans_ld), .busy(busy), .done(done), .err(err),
    .iter_cnt(iter_cnt)
  );

  // Behavioural datapath
  always @(posedge clk) begin
    if (a_ld)   r_a   <= a_sel ? (r_a - r_b) : opa;
    if (b_ld)   r_b   <= b_sel ? (r_b - r_a) : opb;
    if (ans_ld) r_ans <= r_a;
  end

  assign a_gt_b = !kill_flags && (r_a >  r_b);
  assign a_lt_b = !kill_flags && (r_a <  r_b);
  assign a_eq_b = !kill_flags && (r_a == r_b);
  assign a_zero = !kill_flags && (r_a == 16'd0);
  assign b_zero = !kill_flags && (r_b == 16'd0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse start with operands a/b, then follow the run until done or bound.
  // cyc is the cycle number of the done pulse (start sampled in cycle 0).
  task automatic run(input logic [15:0] a, input logic [15:0] b, input int bound,
                     output int cyc, output int nans, output int nboth);
    @(negedge clk);
    opa = a; opb = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1; nans = 0; nboth = 0;
    while (1) begin
      if (ans_ld) nans++;
      if (a_ld && b_ld) nboth++;
      if (done || cyc >= bound) break;
      @(posedge clk); #1;
      cyc++;
    end
    chk("done_seen", done, 1'b1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ld"},   {a_ld, b_ld, a_sel, b_sel, ans_ld}, 5'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_err"},  err, 1'b0);
    chk({tag, "_iter"}, iter_cnt, 16'd0);
  endtask

  int cyc, nans, nboth, ndone;

  initial begin
    rst = 1'b1; start = 1'b0; opa = '0; opb = '0; kill_flags = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // 12,8: two subtracts, answer 4
    run(16'd12, 16'd8, 40, cyc, nans, nboth);
    chk("g12_8_cyc", cyc, 8);
    chk("g12_8_iter", iter_cnt, 2);
    chk("g12_8_err", err, 0);
    chk("g12_8_busy", busy, 1);
    chk("g12_8_nans", nans, 1);
    chk("g12_8_both", nboth, 1);
    @(posedge clk); #1;
    chk("g12_8_ans", r_ans, 4);
    chk("g12_8_idle", busy, 0);

    // 5,5: equal immediately
    run(16'd5, 16'd5, 40, cyc, nans, nboth);
    chk("g5_5_cyc", cyc, 4);
    chk("g5_5_iter", iter_cnt, 0);
    chk("g5_5_err", err, 0);
    chk("g5_5_nans", nans, 1);
    @(posedge clk); #1;
    chk("g5_5_ans", r_ans, 5);

    // 0,7: zero operand aborts, answer untouched
    run(16'd0, 16'd7, 40, cyc, nans, nboth);
    chk("g0_7_cyc", cyc, 3);
    chk("g0_7_err", err, 1);
    chk("g0_7_nans", nans, 0);
    chk("g0_7_iter", iter_cnt, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("g0_7_err_hold", err, 1);
    chk("g0_7_ans_keep", r_ans, 5);

    // 11,1: exactly ITER_MAX steps still succeeds; also clears err
    run(16'd11, 16'd1, 60, cyc, nans, nboth);
    chk("g11_1_cyc", cyc, 24);
    chk("g11_1_iter", iter_cnt, 10);
    chk("g11_1_err", err, 0);
    @(posedge clk); #1;
    chk("g11_1_ans", r_ans, 1);

    // 12,1: one step too many -> timeout abort
    run(16'd12, 16'd1, 60, cyc, nans, nboth);
    chk("g12_1_cyc", cyc, 23);
    chk("g12_1_iter", iter_cnt, 10);
    chk("g12_1_err", err, 1);
    chk("g12_1_nans", nans, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("g12_1_iter_hold", iter_cnt, 10);

    // No compare flag at all -> illegal datapath abort
    kill_flags = 1'b1;
    run(16'd12, 16'd8, 40, cyc, nans, nboth);
    chk("noflag_cyc", cyc, 3);
    chk("noflag_err", err, 1);
    chk("noflag_nans", nans, 0);
    kill_flags = 1'b0;
    @(posedge clk);

    // Reset during the first SUB_A, then a clean 9,6 run
    @(negedge clk);
    opa = 16'd12; opb = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rstmid_suba", {a_ld, a_sel, b_ld}, 3'b110);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_reset_vals("rstmid");
    run(16'd9, 16'd6, 40, cyc, nans, nboth);
    chk("g9_6_cyc", cyc, 8);
    chk("g9_6_iter", iter_cnt, 2);
    @(posedge clk); #1;
    chk("g9_6_ans", r_ans, 3);

    // rst wins over start on the same edge
    @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_ld", {a_ld, b_ld}, 2'b00);
    rst = 1'b0; start = 1'b0;

    // start held high: one run, restart right after DONE
    @(negedge clk);
    opa = 16'd12; opb = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    ndone = 0;
    for (int c = 1; c <= 8; c++) begin
      if (done) ndone++;
      if (c == 8) chk("hold_done_c8", done, 1);
      if (c < 8) begin
        @(posedge clk); #1;
      end
    end
    chk("hold_ndone", ndone, 1);
    @(posedge clk); #1;
    chk("hold_idle_c9", busy, 0);
    @(posedge clk); #1;
    chk("hold_load_c10", {busy, a_ld, b_ld}, 3'b111);
    start = 1'b0;
    cyc = 0;
    while (!done && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    chk("hold_second_done", done, 1);
    chk("hold_second_cyc", cyc, 7);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
